// File: rtl/uart_tx_fifo.sv
// Purpose : 8N1 UART transmitter fed by a small byte FIFO.
// Latency : 2 cycles from an enqueue into an empty, idle block to the start bit on tx.
// Backpr. : tx_ready drops when the FIFO holds FIFO_DEPTH bytes; a tx_valid while full is dropped.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   tx_data, tx_valid   byte offered by the producer
//   tx_ready            combinational, high while the FIFO is not full
//   tx, tx_busy         registered serial line (idles high) and frame-in-progress flag
//   fifo_count          bytes queued, not counting the byte being shifted out
module uart_tx_fifo #(
    parameter int CLOCK_FREQ = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   tx_data,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    output logic                         tx,
    output logic                         tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int BAUD_DIVISOR = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(BAUD_DIVISOR);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;
    localparam logic [CW-1:0] BAUD_LAST  = CW'(BAUD_DIVISOR - 1);
    localparam logic [NW-1:0] FULL_COUNT = NW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [NW-1:0]   count_q;
    logic [7:0]      mem [FIFO_DEPTH];

    logic push, pop, baud_term, have_data;

    assign have_data = (count_q != '0);
    assign tx_ready  = (count_q != FULL_COUNT);
    assign push      = tx_valid && tx_ready;
    assign baud_term = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (have_data) begin
                    pop     = 1'b1;
                    state_d = START;
                    baud_d  = '0;
                end
            end
            START: begin
                if (baud_term) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_term) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_term) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when bytes are waiting.
                    if (have_data) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            shift_d = mem[rd_ptr_q];
        end

        // tx/tx_busy are registered from the next state so the line level
        // appears in the same cycle the FSM enters a state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bit_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr_q] <= tx_data;
        end
    end

    assign tx         = tx_q;
    assign tx_busy    = busy_q;
    assign fifo_count = count_q;

endmodule
